// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character-LCD controller.
//   - lcd_state_e : controller FSM states
//   - LCD_*       : init command bytes, replayed in this order at power-up
//   - INIT_LEN    : number of init bytes
//   - is_long_cmd : true for clear/home commands, which need the long wait
//   - max_u       : helper for sizing the shared down-counter
package lcd_pkg;

  typedef enum logic [2:0] {
    S_PWRON,
    S_LOAD,
    S_SETUP,
    S_EN,
    S_HOLD,
    S_WAIT,
    S_IDLE
  } lcd_state_e;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] LCD_CLEAR    = 8'h01;  // clear display
  localparam logic [7:0] LCD_ENTRY    = 8'h06;  // increment, no shift

  localparam int INIT_LEN = 4;
  localparam int IDX_W    = 2;
  localparam logic [IDX_W-1:0] INIT_LAST = IDX_W'(INIT_LEN - 1);

  // Clear (0x01) and return-home (0x02/0x03) run far longer inside the
  // controller than every other command or data write.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && (data inside {8'h01, 8'h02, 8'h03});
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Power-up init byte table for the HD44780 controller.
// Built only when LCD_AUTO_INIT_EN is defined; without it the host issues
// the init commands itself and no table exists.
// Ports:
//   idx  : init entry index, 0..INIT_LEN-1
//   data : command byte for that entry (all entries are rs=0 commands)
`ifdef LCD_AUTO_INIT_EN
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       data
);

  always_comb begin
    data = LCD_FUNC_SET;
    case (idx)
      2'd0: data = LCD_FUNC_SET;
      2'd1: data = LCD_DISP_ON;
      2'd2: data = LCD_CLEAR;
      2'd3: data = LCD_ENTRY;
      default: data = LCD_FUNC_SET;
    endcase
  end

endmodule
`endif

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character-LCD write controller.
// Turns byte-write requests into timed LCD_DATA/RS/EN waveforms, spacing
// each transfer by the controller's execution time. With LCD_AUTO_INIT_EN
// defined it also waits for power-up and plays the init sequence itself;
// without it, the controller is ready one cycle after reset.
//
// Handshake: a request transfers on a rising clk edge where i_req_vld and
// o_req_rdy are both 1. o_req_rdy is 1 only while idle; i_req_vld is ignored
// otherwise and nothing is queued, so the requester holds i_req_vld and its
// rs/data stable until the transfer edge.
//
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_req_vld/o_req_rdy, i_req_rs, i_req_data : write request (rs=1 data)
//   o_busy        : FSM not idle
//   o_init_done   : init complete, sticky until reset
//   o_lcd_*       : registered LCD pad drives (rw is always 0)
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRON = 410000,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EN    = 13,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_CMD   = 1100,
  parameter int unsigned T_CLR   = 45000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_vld,
  output logic       o_req_rdy,
  input  logic       i_req_rs,
  input  logic [7:0] i_req_data,
  output logic       o_busy,
  output logic       o_init_done,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_en,
  output logic       o_lcd_rw,
  output logic       o_lcd_on
);

  localparam int unsigned T_MAX = max_u(max_u(max_u(T_PWRON, T_SETUP), max_u(T_EN, T_HOLD)),
                                        max_u(T_CMD, T_CLR));
  localparam int CNT_W = $clog2(T_MAX) + 1;

  // Counter reload values: a phase lasting T cycles loads T-1 on entry
  // and moves on when the counter reads zero.
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(T_CLR - 1);

  lcd_state_e       state;
  logic [CNT_W-1:0] cnt;

`ifdef LCD_AUTO_INIT_EN
  localparam logic [CNT_W-1:0] LD_PWRON = CNT_W'(T_PWRON - 1);

  logic [IDX_W-1:0] idx;
  logic [7:0]       rom_data;

  lcd_init_rom u_init_rom (
    .idx  (idx),
    .data (rom_data)
  );
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_PWRON;
      cnt         <= '0;
      o_req_rdy   <= 1'b0;
      o_busy      <= 1'b1;
      o_init_done <= 1'b0;
      o_lcd_data  <= 8'h00;
      o_lcd_rs    <= 1'b0;
      o_lcd_en    <= 1'b0;
      o_lcd_rw    <= 1'b0;
      o_lcd_on    <= 1'b0;
`ifdef LCD_AUTO_INIT_EN
      idx         <= '0;
`endif
    end else begin
      case (state)
        S_PWRON: begin
`ifdef LCD_AUTO_INIT_EN
          // o_lcd_on is still 0 only on the first cycle out of reset; use
          // that cycle to load the power-up wait into the cleared counter.
          if (!o_lcd_on) begin
            o_lcd_on <= 1'b1;
            cnt      <= LD_PWRON;
          end else if (cnt == '0) begin
            state <= S_LOAD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
`else
          o_lcd_on    <= 1'b1;
          o_init_done <= 1'b1;
          o_req_rdy   <= 1'b1;
          o_busy      <= 1'b0;
          state       <= S_IDLE;
`endif
        end

        S_LOAD: begin
`ifdef LCD_AUTO_INIT_EN
          o_lcd_rs   <= 1'b0;
          o_lcd_data <= rom_data;
          cnt        <= LD_SETUP;
          state      <= S_SETUP;
`else
          state <= S_PWRON;
`endif
        end

        S_SETUP: begin
          if (cnt == '0) begin
            o_lcd_en <= 1'b1;
            cnt      <= LD_EN;
            state    <= S_EN;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_EN: begin
          if (cnt == '0) begin
            o_lcd_en <= 1'b0;
            cnt      <= LD_HOLD;
            state    <= S_HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_HOLD: begin
          if (cnt == '0) begin
            // rs/data are still the latched byte, so classify it here.
            cnt   <= is_long_cmd(o_lcd_rs, o_lcd_data) ? LD_CLR : LD_CMD;
            state <= S_WAIT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_WAIT: begin
          if (cnt == '0) begin
`ifdef LCD_AUTO_INIT_EN
            if (!o_init_done && (idx != INIT_LAST)) begin
              idx   <= idx + IDX_W'(1);
              state <= S_LOAD;
            end else begin
              o_init_done <= 1'b1;
              o_req_rdy   <= 1'b1;
              o_busy      <= 1'b0;
              state       <= S_IDLE;
            end
`else
            o_req_rdy <= 1'b1;
            o_busy    <= 1'b0;
            state     <= S_IDLE;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_IDLE: begin
          if (i_req_vld && o_req_rdy) begin
            o_lcd_rs   <= i_req_rs;
            o_lcd_data <= i_req_data;
            cnt        <= LD_SETUP;
            o_req_rdy  <= 1'b0;
            o_busy     <= 1'b1;
            state      <= S_SETUP;
          end
        end

        default: state <= S_PWRON;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed bench for lcd_hd44780_ctrl with short timing parameters.
// Timing convention: edge k is the rising edge that accepts a request;
// "j" counts falling edges after it (j=0 is the falling edge right after k).
// With T_SETUP=1, T_EN=3, T_HOLD=1: EN is 1 for j=1..3, rdy returns at
// j = 1+3+1+Twait.
// Init (LCD_AUTO_INIT_EN): cyc is 1 just after the first edge out of reset.
// Power-on wait takes 101 edges, then LOAD and SETUP, so the EN rises are
// seen at cyc 103, 119 (+16), 135 (+16), 191 (+56, clear), and rdy at 205.
module tb_lcd_hd44780_ctrl;

  localparam int T_PWRON = 100;
  localparam int T_SETUP = 1;
  localparam int T_EN    = 3;
  localparam int T_HOLD  = 1;
  localparam int T_CMD   = 10;
  localparam int T_CLR   = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_vld;
  logic       req_rdy;
  logic       req_rs;
  logic [7:0] req_data;
  logic       busy;
  logic       init_done;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_en;
  logic       lcd_rw;
  logic       lcd_on;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  lcd_hd44780_ctrl #(
    .T_PWRON (T_PWRON),
    .T_SETUP (T_SETUP),
    .T_EN    (T_EN),
    .T_HOLD  (T_HOLD),
    .T_CMD   (T_CMD),
    .T_CLR   (T_CLR)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_vld   (req_vld),
    .o_req_rdy   (req_rdy),
    .i_req_rs    (req_rs),
    .i_req_data  (req_data),
    .o_busy      (busy),
    .o_init_done (init_done),
    .o_lcd_data  (lcd_data),
    .o_lcd_rs    (lcd_rs),
    .o_lcd_en    (lcd_en),
    .o_lcd_rw    (lcd_rw),
    .o_lcd_on    (lcd_on)
  );

  // ---------------- clock / reset-relative cycle count ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // ---------------- EN pulse monitor ----------------
  logic [8:0] obs_q[$];    // {rs, data} at each EN rise
  int         rise_q[$];   // cyc at each EN rise
  int         width_q[$];  // EN high width in cycles
  logic [8:0] exp_q[$];    // expected {rs, data} per pulse
  logic       en_d = 1'b0;
  int         w = 0;

  always @(negedge clk) begin
    if (lcd_en && !en_d) begin
      obs_q.push_back({lcd_rs, lcd_data});
      rise_q.push_back(cyc);
      w = 1;
    end else if (lcd_en) begin
      w = w + 1;
    end else if (en_d) begin
      width_q.push_back(w);
    end
    en_d = lcd_en;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(input string tag, input int budget);
    int c = 0;
    while (req_rdy !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) check({tag, "_timeout"}, 32'(req_rdy), 32'd1);
  endtask

  // Compare pulses recorded from index bo onward against exp_q.
  task automatic check_pulses(input string tag, input int bo, input int n, input int width);
    logic [8:0] e;
    check({tag, "_count"}, 32'(obs_q.size() - bo), 32'(n));
    for (int i = 0; i < n; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
      check({tag, "_byte"}, (bo + i < obs_q.size()) ? 32'(obs_q[bo + i]) : 32'hDEAD, 32'(e));
      check({tag, "_width"}, (bo + i < width_q.size()) ? 32'(width_q[bo + i]) : 32'hDEAD,
            32'(width));
    end
  endtask

  // Called at the falling edge just after the first edge out of reset.
  task automatic check_init(input int bo);
`ifdef LCD_AUTO_INIT_EN
    int exp_rise[4] = '{103, 119, 135, 191};
    check("pwron_rdy", 32'(req_rdy), 32'd0);
    check("pwron_init_done", 32'(init_done), 32'd0);
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h006);
    wait_rdy("init", 1000);
    check("init_rdy_cycle", 32'(cyc), 32'd205);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++)
      check("init_rise_cycle", (bo + i < rise_q.size()) ? 32'(rise_q[bo + i]) : 32'hDEAD,
            32'(exp_rise[i]));
    check_pulses("init", bo, 4, T_EN);
`else
    check("noinit_rdy", 32'(req_rdy), 32'd1);
    repeat (20) @(negedge clk);
    check("noinit_no_en", 32'(obs_q.size() - bo), 32'd0);
`endif
    check("init_done", 32'(init_done), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  // One request with cycle-by-cycle checks of EN and rdy.
  task automatic send_check(input string tag, input logic rs, input logic [7:0] d,
                            input int twait);
    int last;
    last = T_SETUP + T_EN + T_HOLD + twait;
    wait_rdy(tag, 2000);
    req_rs   = rs;
    req_data = d;
    req_vld  = 1'b1;
    @(posedge clk);
    #1 req_vld = 1'b0;
    for (int j = 0; j <= last; j++) begin
      @(negedge clk);
      check({tag, "_en"}, 32'(lcd_en), 32'(j >= T_SETUP && j < T_SETUP + T_EN));
      if (j == T_SETUP) begin
        check({tag, "_data"}, 32'(lcd_data), 32'(d));
        check({tag, "_rs"}, 32'(lcd_rs), 32'(rs));
        check({tag, "_rw"}, 32'(lcd_rw), 32'd0);
      end
      if (j >= last - 1) check({tag, "_rdy"}, 32'(req_rdy), 32'(j == last));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int  bo;
    int  n;
    logic acc;

    rst      = 1'b1;
    req_vld  = 1'b0;
    req_rs   = 1'b0;
    req_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset values
    check("rst_data", 32'(lcd_data), 32'h00);
    check("rst_rs", 32'(lcd_rs), 32'd0);
    check("rst_en", 32'(lcd_en), 32'd0);
    check("rst_rw", 32'(lcd_rw), 32'd0);
    check("rst_on", 32'(lcd_on), 32'd0);
    check("rst_rdy", 32'(req_rdy), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_init_done", 32'(init_done), 32'd0);

    rst = 1'b0;
    @(negedge clk);
    check("on_after_rst", 32'(lcd_on), 32'd1);
    check_init(0);

    // Host writes: character, clear vs same byte as data, home boundaries
    send_check("char_A", 1'b1, 8'h41, T_CMD);
    send_check("clear", 1'b0, 8'h01, T_CLR);
    send_check("data_01", 1'b1, 8'h01, T_CMD);
    send_check("home_02", 1'b0, 8'h02, T_CLR);
    send_check("home_03", 1'b0, 8'h03, T_CLR);
    send_check("cmd_04", 1'b0, 8'h04, T_CMD);
    send_check("cmd_00", 1'b0, 8'h00, T_CMD);

    // Back-to-back: vld held high, next byte presented after each accept
    bo = obs_q.size();
    for (int i = 0; i < 4; i++) exp_q.push_back(9'h130 + 9'(i));
    n        = 0;
    req_rs   = 1'b1;
    req_data = 8'h30;
    req_vld  = 1'b1;
    for (int c = 0; c < 1000 && n < 4; c++) begin
      acc = req_rdy;
      @(negedge clk);
      if (acc) begin
        n++;
        if (n == 4) req_vld = 1'b0;
        else req_data = 8'(8'h30 + n);
      end
    end
    req_vld = 1'b0;
    check("stream_accepts", 32'(n), 32'd4);
    wait_rdy("stream", 200);
    repeat (2) @(negedge clk);
    check_pulses("stream", bo, 4, T_EN);

    // Reset while EN is high
    req_rs   = 1'b1;
    req_data = 8'h55;
    req_vld  = 1'b1;
    @(posedge clk);
    #1 req_vld = 1'b0;
    n = 0;
    while (lcd_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("midrst_en_seen", 32'(lcd_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_en", 32'(lcd_en), 32'd0);
    check("midrst_init_done", 32'(init_done), 32'd0);
    check("midrst_rdy", 32'(req_rdy), 32'd0);
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_data", 32'(lcd_data), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    #1 bo = obs_q.size();
    @(negedge clk);
    check("midrst_on", 32'(lcd_on), 32'd1);
    check_init(bo);

    send_check("post_rst_B", 1'b1, 8'h42, T_CMD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
